// File: rtl/fir_tap_delay_line_if.sv
// Stream bundle for the FIR tap delay line: sample input side and tap-vector output side.
// The slave modport is the delay line itself; master is the source/sink driving it.
interface fir_tap_delay_line_if #(
   parameter int DATA_W   = 12,
   parameter int TAPS     = 4,
   parameter int CHANNELS = 1
);
   localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic                     in_valid;
   logic                     in_ready;
   logic [CH_W-1:0]          in_ch;
   logic signed [DATA_W-1:0] in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [CH_W-1:0]          out_ch;
   logic [TAPS*DATA_W-1:0]   out_taps;
   logic                     out_primed;
   logic                     err_ch;

   modport master (
      output in_valid, in_ch, in_data, out_ready,
      input  in_ready, out_valid, out_ch, out_taps, out_primed, err_ch
   );

   modport slave (
      input  in_valid, in_ch, in_data, out_ready,
      output in_ready, out_valid, out_ch, out_taps, out_primed, err_ch
   );
endinterface

// File: rtl/fir_tap_delay_line.sv
// Multi-channel tap delay line: per-channel TAPS-deep sample history, shifted on each
// accepted sample and presented as a full tap vector one cycle later.
module fir_tap_delay_line #(
   parameter int DATA_W   = 12,
   parameter int TAPS     = 4,
   parameter int CHANNELS = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   fir_tap_delay_line_if.slave        bus
);
   localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int FILL_W = $clog2(TAPS + 1);
   localparam logic [FILL_W-1:0] TAPS_F   = FILL_W'(TAPS);
   localparam logic [CH_W:0]     CH_LIMIT = (CH_W + 1)'(CHANNELS);

   logic [DATA_W-1:0]      hist [CHANNELS][TAPS];
   logic [FILL_W-1:0]      fill [CHANNELS];

   logic [DATA_W-1:0]      row       [TAPS];
   logic [DATA_W-1:0]      shift_row [TAPS];
   logic [TAPS*DATA_W-1:0] shift_vec;
   logic [FILL_W-1:0]      fill_row;
   logic [FILL_W-1:0]      fill_nxt;
   logic                   accept;
   logic                   ch_ok;

   assign bus.in_ready = !flush && (!bus.out_valid || bus.out_ready);
   assign accept       = bus.in_valid && bus.in_ready;
   assign ch_ok        = {1'b0, bus.in_ch} < CH_LIMIT;

   // Select the addressed channel by compare rather than indexing, so an
   // out-of-range in_ch never reads past the history array.
   always_comb begin
      row      = '{default: '0};
      fill_row = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (bus.in_ch == CH_W'(c)) begin
            row      = hist[c];
            fill_row = fill[c];
         end
      end
      shift_row[0] = bus.in_data;
      for (int k = 1; k < TAPS; k++) begin
         shift_row[k] = row[k-1];
      end
      shift_vec = '0;
      for (int k = 0; k < TAPS; k++) begin
         shift_vec[k*DATA_W +: DATA_W] = shift_row[k];
      end
      fill_nxt = (fill_row == TAPS_F) ? fill_row : fill_row + 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < CHANNELS; c++) begin
            fill[c] <= '0;
            for (int k = 0; k < TAPS; k++) hist[c][k] <= '0;
         end
         bus.out_valid  <= 1'b0;
         bus.out_ch     <= '0;
         bus.out_taps   <= '0;
         bus.out_primed <= 1'b0;
         bus.err_ch     <= 1'b0;
      end else begin
         bus.err_ch <= 1'b0;
         if (flush) begin
            for (int c = 0; c < CHANNELS; c++) begin
               fill[c] <= '0;
               for (int k = 0; k < TAPS; k++) hist[c][k] <= '0;
            end
            bus.out_valid  <= 1'b0;
            bus.out_ch     <= '0;
            bus.out_taps   <= '0;
            bus.out_primed <= 1'b0;
         end else if (accept && ch_ok) begin
            for (int c = 0; c < CHANNELS; c++) begin
               if (bus.in_ch == CH_W'(c)) begin
                  hist[c] <= shift_row;
                  fill[c] <= fill_nxt;
               end
            end
            bus.out_valid  <= 1'b1;
            bus.out_ch     <= bus.in_ch;
            bus.out_taps   <= shift_vec;
            bus.out_primed <= (fill_nxt == TAPS_F);
         end else begin
            // A dropped bad-channel sample still lets a pending vector be consumed.
            if (accept) bus.err_ch <= 1'b1;
            if (bus.out_ready) bus.out_valid <= 1'b0;
         end
      end
   end
endmodule
